// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types and constants for the GMII transmit framer
//
// Purpose : state encoding, preamble/SFD bytes, CRC-32 polynomial and the
//           default frame-size limits used by mac_tx_framer and crc32.
// Ports   : none (package).

package eth_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SFD      = 3'd2,
      ST_DATA     = 3'd3,
      ST_PAD      = 3'd4,
      ST_FCS      = 3'd5,
      ST_DROP     = 3'd6,
      ST_IFG      = 3'd7
   } mac_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;

   localparam int MIN_FRAME_DEF = 60;
   localparam int MAX_FRAME_DEF = 1514;

   // Ethernet shifts bits LSB first, so the engine uses the bit-reversed polynomial.
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

endpackage

// File: rtl/crc32.sv
// rtl/crc32.sv - byte-wide reflected CRC-32 accumulator
//
// Purpose : folds one byte per enabled cycle into a running CRC-32
//           (init FFFFFFFF, reflected, final complement on the output).
// Ports   : i_clk      clock
//           i_reset    synchronous active-high clear back to FFFFFFFF
//           i_crc_en   fold i_data_in into the CRC this cycle
//           i_data_in  byte to fold
//           o_crc_out  complemented CRC of all bytes folded since the clear

module crc32
   import eth_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_crc_en,
   input  logic [7:0]  i_data_in,
   output logic [31:0] o_crc_out
);

   logic [31:0] r_crc;
   logic [31:0] w_crc_nxt;

   always_comb begin
      w_crc_nxt = r_crc ^ {24'd0, i_data_in};
      for (int i = 0; i < 8; i++) begin
         w_crc_nxt = w_crc_nxt[0] ? ((w_crc_nxt >> 1) ^ CRC_POLY_REFL) : (w_crc_nxt >> 1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_crc <= 32'hFFFF_FFFF;
      end else if (i_crc_en) begin
         r_crc <= w_crc_nxt;
      end
   end

   assign o_crc_out = ~r_crc;

endmodule

// File: rtl/mac_tx_framer.sv
// rtl/mac_tx_framer.sv - GMII transmit framer fed from a first-word-fall-through FIFO
//
// Purpose : wraps FIFO frames with preamble/SFD, pads short frames, appends the
//           FCS, enforces the inter-frame gap, and aborts on underrun or oversize.
// Ports   : i_clk, i_reset          clock, synchronous active-high reset
//           i_rd_data/valid/last    FIFO head byte, not-empty, end-of-frame flag
//           o_rd_en                 FIFO pop (byte consumed when o_rd_en & i_rd_valid)
//           o_txd/o_txen/o_txer     registered GMII transmit outputs
//           o_mac_tr_state          current state encoding
//           o_frame_done            pulse with the final byte of a good frame
//           o_underrun              pulse when the FIFO ran dry mid-frame

module mac_tx_framer
   import eth_pkg::*;
#(
   parameter int PREAMBLE_LEN = 7,
   parameter int IFG_LEN      = 12,
   parameter int MIN_FRAME    = MIN_FRAME_DEF,
   parameter int MAX_FRAME    = MAX_FRAME_DEF,
   parameter int FCS_EN       = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_rd_data,
   input  logic       i_rd_valid,
   input  logic       i_rd_last,
   output logic       o_rd_en,
   output logic [7:0] o_txd,
   output logic       o_txen,
   output logic       o_txer,
   output logic [2:0] o_mac_tr_state,
   output logic       o_frame_done,
   output logic       o_underrun
);

   localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
   localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
   localparam logic [10:0] MIN_F    = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_F    = 11'(MAX_FRAME);

   mac_state_t  r_state, w_state_nxt;
   logic [7:0]  r_cnt, w_cnt_nxt;
   logic [10:0] r_byte_cnt, w_byte_cnt_nxt, w_inc;
   logic [7:0]  r_txd, w_txd_nxt;
   logic        r_txen, w_txen_nxt;
   logic        r_txer, w_txer_nxt;
   logic        r_done, w_done_nxt;
   logic        r_underrun, w_underrun_nxt;
   logic        w_rd_en, w_crc_en, w_crc_clr;
   logic [7:0]  w_crc_data, w_fcs_byte;
   logic [31:0] w_fcs;

   assign w_crc_clr  = i_reset || (r_state == ST_IDLE);
   assign w_inc      = r_byte_cnt + 11'd1;
   assign w_fcs_byte = w_fcs[{r_cnt[1:0], 3'b000} +: 8];

   crc32 u_crc32 (
      .i_clk     (i_clk),
      .i_reset   (w_crc_clr),
      .i_crc_en  (w_crc_en),
      .i_data_in (w_crc_data),
      .o_crc_out (w_fcs)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_byte_cnt_nxt = r_byte_cnt;
      w_txd_nxt      = 8'h00;
      w_txen_nxt     = 1'b0;
      w_txer_nxt     = 1'b0;
      w_done_nxt     = 1'b0;
      w_underrun_nxt = 1'b0;
      w_rd_en        = 1'b0;
      w_crc_en       = 1'b0;
      w_crc_data     = i_rd_data;

      case (r_state)
         ST_IDLE: begin
            w_cnt_nxt      = 8'd0;
            w_byte_cnt_nxt = 11'd0;
            if (i_rd_valid) w_state_nxt = ST_PREAMBLE;
         end
         ST_PREAMBLE: begin
            w_txd_nxt  = PREAMBLE_BYTE;
            w_txen_nxt = 1'b1;
            if (r_cnt == PRE_LAST) begin
               w_cnt_nxt   = 8'd0;
               w_state_nxt = ST_SFD;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_SFD: begin
            w_txd_nxt   = SFD_BYTE;
            w_txen_nxt  = 1'b1;
            w_state_nxt = ST_DATA;
         end
         ST_DATA: begin
            w_rd_en    = 1'b1;
            w_txen_nxt = 1'b1;
            if (i_rd_valid) begin
               w_txd_nxt      = i_rd_data;
               w_byte_cnt_nxt = w_inc;
               w_crc_en       = 1'b1;
               if (i_rd_last) begin
                  if (w_inc < MIN_F) begin
                     w_state_nxt = ST_PAD;
                  end else if (FCS_EN != 0) begin
                     w_state_nxt = ST_FCS;
                  end else begin
                     w_state_nxt = ST_IFG;
                     w_done_nxt  = 1'b1;
                  end
               end else if (w_inc == MAX_F) begin
                  // Oversize: flag this byte and swallow the rest of the frame.
                  w_txer_nxt  = 1'b1;
                  w_state_nxt = ST_DROP;
               end
            end else begin
               // FIFO ran dry mid-frame: poison the line and abandon the frame.
               w_txer_nxt     = 1'b1;
               w_underrun_nxt = 1'b1;
               w_state_nxt    = ST_IFG;
            end
         end
         ST_PAD: begin
            w_txen_nxt     = 1'b1;
            w_crc_en       = 1'b1;
            w_crc_data     = 8'h00;
            w_byte_cnt_nxt = w_inc;
            if (w_inc >= MIN_F) begin
               if (FCS_EN != 0) begin
                  w_state_nxt = ST_FCS;
               end else begin
                  w_state_nxt = ST_IFG;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         ST_FCS: begin
            w_txd_nxt  = w_fcs_byte;
            w_txen_nxt = 1'b1;
            if (r_cnt[1:0] == 2'd3) begin
               w_cnt_nxt   = 8'd0;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IFG;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_DROP: begin
            w_rd_en = 1'b1;
            if (i_rd_valid && i_rd_last) w_state_nxt = ST_IFG;
         end
         ST_IFG: begin
            if (r_cnt == IFG_LAST) begin
               w_cnt_nxt   = 8'd0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 8'd0;
         r_byte_cnt <= 11'd0;
         r_txd      <= 8'h00;
         r_txen     <= 1'b0;
         r_txer     <= 1'b0;
         r_done     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_byte_cnt <= w_byte_cnt_nxt;
         r_txd      <= w_txd_nxt;
         r_txen     <= w_txen_nxt;
         r_txer     <= w_txer_nxt;
         r_done     <= w_done_nxt;
         r_underrun <= w_underrun_nxt;
      end
   end

   // Gated by reset so an aborted frame leaves its remaining bytes in the FIFO.
   assign o_rd_en        = w_rd_en & ~i_reset;
   assign o_txd          = r_txd;
   assign o_txen         = r_txen;
   assign o_txer         = r_txer;
   assign o_mac_tr_state = r_state;
   assign o_frame_done   = r_done;
   assign o_underrun     = r_underrun;

endmodule

// File: doc/mac_tx_framer.md
MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

Interface
REQ-001 Parameter PREAMBLE_LEN, default 7: number of 8'h55 preamble bytes before the SFD.
REQ-002 Parameter IFG_LEN, default 12: number of idle cycles after each frame.
REQ-003 Parameter MIN_FRAME, default 60: minimum bytes before the FCS; shorter frames are zero-padded; 0 disables padding.
REQ-004 Parameter MAX_FRAME, default 1514: maximum bytes before the FCS.
REQ-005 Parameter FCS_EN, default 1: 1 appends a 4-byte FCS; 0 omits it.
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 rd_data  in  8  FIFO head byte (first-word-fall-through), valid while rd_valid=1.
REQ-009 rd_valid  in  1  FIFO not empty.
REQ-010 rd_last  in  1  marks rd_data as the final byte of its frame.
REQ-011 rd_en  out  1  FIFO pop; a byte is consumed in a cycle with rd_en=1 and rd_valid=1.
REQ-012 txd  out  8  GMII transmit data, registered.
REQ-013 txen  out  1  GMII transmit enable, registered.
REQ-014 txer  out  1  GMII transmit error, registered.
REQ-015 mac_tr_state  out  3  current state encoding, for debug.
REQ-016 frame_done  out  1  one-cycle pulse when the last FCS byte (or the last data/pad byte if FCS_EN=0) is registered onto txd.
REQ-017 underrun  out  1  one-cycle pulse when an underrun abort occurs.

Function
REQ-018 States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DROP, IFG.
REQ-019 Output timing: the byte selected in state S during cycle n appears on txd/txen/txer at edge n+1.
REQ-020 IDLE to PREAMBLE when rd_valid=1; no byte is consumed.
REQ-021 PREAMBLE drives 8'h55 for PREAMBLE_LEN cycles; SFD drives 8'hD5 for 1 cycle; then DATA.
REQ-022 DATA: rd_en=1; each consumed byte goes to txd and increments the 11-bit byte_cnt.
REQ-023 DATA exit on a consumed rd_last byte:
  - to PAD if byte_cnt+1 < MIN_FRAME;
  - else to FCS if FCS_EN=1;
  - else to IFG.
REQ-024 DATA with rd_valid=0 before rd_last (underrun):
  - drive txd=0 with txer=1 for one cycle;
  - pulse underrun;
  - go to IFG with no FCS.
REQ-025 byte_cnt reaching MAX_FRAME without rd_last:
  - txer=1 on that byte;
  - go to DROP, which keeps rd_en=1 and txen=0 and discards bytes through rd_last;
  - then IFG; frame_done is not pulsed.
REQ-026 rd_last on exactly byte MAX_FRAME is legal and follows REQ-023.
REQ-027 PAD drives 8'h00 until byte_cnt = MIN_FRAME; then FCS or IFG per FCS_EN; rd_en=0.
REQ-028 FCS computation: CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF, final complement) over DATA and PAD bytes only.
REQ-029 FCS transmission: 4 bytes, least-significant byte first.
REQ-030 txen=1 for PREAMBLE, SFD, DATA, PAD and FCS bytes; 0 otherwise.
REQ-031 IFG holds txen=0 for IFG_LEN cycles, then returns to IDLE; rd_valid is ignored during IFG.
REQ-032 rd_en=0 in every state other than DATA and DROP.

Reset
REQ-033 reset=1 at an edge forces state=IDLE and byte_cnt=0 and clears the CRC.
REQ-034 Reset values: txd=0, txen=0, txer=0, rd_en=0, frame_done=0, underrun=0.
REQ-035 Reset mid-frame aborts the frame; txen is 0 from the following cycle; the FIFO contents are untouched.

Structure
REQ-036 Package eth_pkg holds the state enum, 8'h55, 8'hD5, the CRC polynomial, and the MIN_FRAME/MAX_FRAME defaults.
REQ-037 One sub-module, crc32 (byte-wide: clk, reset, crc_en, data_in, crc_out), is cleared in IDLE.
REQ-038 crc32 is enabled on consumed DATA bytes and PAD cycles.

Verification
REQ-039 100-byte frame, defaults:
  - txen high 112 cycles: 7x55, D5, 100 data bytes, 4 FCS bytes;
  - frame_done pulses once;
  - then 12 idle cycles.
REQ-040 10-byte frame:
  - 50 pad bytes of 00;
  - txen high 72 cycles;
  - FCS computed over 60 bytes.
REQ-041 MIN_FRAME=0, payload ASCII "123456789" -> FCS bytes 26 39 F4 CB in that order.
REQ-042 rd_valid drops after byte 20 of 40:
  - byte 21 slot is txd=00 with txer=1;
  - underrun pulses;
  - no FCS;
  - IDLE after 12 cycles.
REQ-043 1520-byte frame:
  - txer=1 on byte 1514;
  - 6 bytes discarded with txen=0;
  - no frame_done;
  - next frame transmits normally.
REQ-044 reset during DATA byte 30 -> txen=0 and rd_en=0 next cycle, mac_tr_state=IDLE.
